pipeline_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage 64-bit pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates PC/pipeline-register write enables and flushes for three cases: load-use hazards, taken branches resolved at EX/MEM, and multi-cycle data-memory accesses.
- Sits beside the datapath; consumes only control fields already carried in the pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/load_use_detect.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  // Width of the exported FSM state.
  localparam int unsigned StateW = 2;

  // Default register-address width (32 architectural registers).
  localparam int unsigned RegAwDefault = 5;

  // Width of the memory wait counter; covers the full MEM_TIMEOUT range.
  localparam int unsigned WaitCntW = 16;

  // Width of the residual flush counter; covers FLUSH_CYCLES up to 7.
  localparam int unsigned FlushCntW = 3;

  // Sequencer states. Encoding 2'd3 is unused and recovers to StRun.
  typedef enum logic [StateW-1:0] {
    StRun     = 2'd0,
    StFlush   = 2'd1,
    StMemWait = 2'd2
  } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags when the instruction in IF/ID reads the
// destination of a load sitting in ID/EX. x0 is hard-wired zero and never stalls.
module load_use_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic [REG_AW-1:0] ifid_rs1_i,
  input  logic [REG_AW-1:0] ifid_rs2_i,
  output logic              lu_o
);

  // Pure comparator, no state.
  always_comb begin
    lu_o = idex_memread_i && (idex_rd_i != '0) &&
           ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline registers.
// Handles load-use bubbles, taken branches resolved at EX/MEM and
// multi-cycle data-memory accesses. Outputs are combinational from the
// registered state plus current inputs so stalls take effect with zero latency.
// Optional build macro: HAZARD_PERF_EN adds stall_cnt / flush_cnt counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned REG_AW       = RegAwDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              exm_branch,
  input  logic              exm_zero,
  input  logic              exm_memread,
  input  logic              exm_memwrite,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exm_write,
  output logic              exm_flush,
  output logic              memwb_write,
  output logic              dmem_req,
  output logic              mem_err,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic [StateW-1:0] state
);

  localparam bit                   MultiFlush = (FLUSH_CYCLES > 1);
  localparam logic [FlushCntW-1:0] FlushInit  = FlushCntW'(FLUSH_CYCLES - 1);
  localparam logic [WaitCntW-1:0]  TimeoutVal = WaitCntW'(MEM_TIMEOUT);

  state_e               state_q, state_d;
  logic [FlushCntW-1:0] fcnt_q, fcnt_d;
  logic [WaitCntW-1:0]  wcnt_q, wcnt_d;
  logic                 mem_err_q, mem_err_d;

  logic mem_acc;
  logic taken;
  logic mem_stall;
  logic lu;

  assign mem_acc   = exm_memread | exm_memwrite;
  assign taken     = exm_branch & exm_zero;
  assign mem_stall = mem_acc & ~dmem_ready;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .idex_memread_i(idex_memread),
    .idex_rd_i     (idex_rd),
    .ifid_rs1_i    (ifid_rs1),
    .ifid_rs2_i    (ifid_rs2),
    .lu_o          (lu)
  );

  // State, counters and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StRun;
      fcnt_q    <= '0;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    wcnt_d    = wcnt_q;
    mem_err_d = mem_err_q;
    case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d = StMemWait;
          wcnt_d  = WaitCntW'(1);
        end else if (taken) begin
          if (MultiFlush) begin
            state_d = StFlush;
            fcnt_d  = FlushInit;
          end else begin
            state_d = StRun;
            fcnt_d  = '0;
          end
        end
      end
      StFlush: begin
        // A memory stall freezes the residual flush count until release.
        if (mem_stall) begin
          state_d = StMemWait;
          wcnt_d  = WaitCntW'(1);
        end else if (fcnt_q <= FlushCntW'(1)) begin
          state_d = StRun;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FlushCntW'(1);
        end
      end
      StMemWait: begin
        if (!dmem_ready) begin
          if (wcnt_q < TimeoutVal) begin
            wcnt_d = wcnt_q + WaitCntW'(1);
          end
        end else begin
          wcnt_d = '0;
          if (taken) begin
            if (MultiFlush) begin
              state_d = StFlush;
              fcnt_d  = FlushInit;
            end else begin
              state_d = StRun;
              fcnt_d  = '0;
            end
          end else if (fcnt_q != '0) begin
            state_d = StFlush;
          end else begin
            state_d = StRun;
          end
        end
      end
      default: begin
        state_d = StRun;
        fcnt_d  = '0;
        wcnt_d  = '0;
      end
    endcase
    // Timeout is sticky; the FSM keeps waiting regardless.
    if (wcnt_d >= TimeoutVal) begin
      mem_err_d = 1'b1;
    end
  end

  // Enables, flushes and memory request; reset overrides asynchronously.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    exm_write   = 1'b0;
    memwb_write = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exm_flush   = 1'b0;
    dmem_req    = 1'b0;
    if (!reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exm_flush  = 1'b1;
    end else begin
      case (state_q)
        StRun: begin
          dmem_req = mem_acc;
          if (mem_stall) begin
            // Freeze everything until memory answers.
          end else if (taken) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            exm_write   = 1'b1;
            memwb_write = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exm_flush   = 1'b1;
          end else if (lu) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX.
            exm_write   = 1'b1;
            memwb_write = 1'b1;
            idex_flush  = 1'b1;
          end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            exm_write   = 1'b1;
            memwb_write = 1'b1;
          end
        end
        StFlush: begin
          // Load-use is ignored here: the younger stages are being squashed.
          if (!mem_stall) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            exm_write   = 1'b1;
            memwb_write = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
          end
        end
        StMemWait: begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            exm_write   = 1'b1;
            memwb_write = 1'b1;
            if (taken) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
              exm_flush  = 1'b1;
            end
          end
        end
        default: begin
          // Unreachable encoding: hold everything for one cycle.
        end
      endcase
    end
  end

  assign mem_err = mem_err_q;
  assign state   = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        taken_evt;

  // A taken branch is acted on in RUN (no stall) or on a MEM_WAIT release.
  always_comb begin
    taken_evt   = taken && (((state_q == StRun) && !mem_stall) ||
                            ((state_q == StMemWait) && dmem_ready));
    stall_cnt_d = stall_cnt_q + {31'd0, ~pc_write};
    flush_cnt_d = flush_cnt_q + {31'd0, taken_evt};
  end

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with FLUSH_CYCLES=3, MEM_TIMEOUT=8.
// A behavioural model tracks "waiting for memory", "flush cycles left" and
// "cycles waited" as plain integers and predicts every output each cycle.
module tb_pipeline_hazard_ctrl;

  localparam int FC = 3;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       idex_memread, exm_branch, exm_zero, exm_memread, exm_memwrite, dmem_ready;
  logic       pc_write, ifid_write, ifid_flush, idex_flush, exm_write, exm_flush;
  logic       memwb_write, dmem_req, mem_err;
  logic [1:0] state;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  logic [7:0] out_vec;
  assign out_vec = {pc_write, ifid_write, exm_write, memwb_write,
                    ifid_flush, idex_flush, exm_flush, dmem_req};

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  bit m_wait;
  int m_flush_left;
  int m_waited;
  bit m_err;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(FC),
    .MEM_TIMEOUT (TO),
    .REG_AW      (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ifid_rs1    (ifid_rs1),
    .ifid_rs2    (ifid_rs2),
    .idex_memread(idex_memread),
    .idex_rd     (idex_rd),
    .exm_branch  (exm_branch),
    .exm_zero    (exm_zero),
    .exm_memread (exm_memread),
    .exm_memwrite(exm_memwrite),
    .dmem_ready  (dmem_ready),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exm_write   (exm_write),
    .exm_flush   (exm_flush),
    .memwb_write (memwb_write),
    .dmem_req    (dmem_req),
    .mem_err     (mem_err),
`ifdef HAZARD_PERF_EN
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
`endif
    .state       (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_state();
    if (m_wait) return 2;
    if (m_flush_left > 0) return 1;
    return 0;
  endfunction

  // Expected {pc,ifid_w,exm_w,memwb_w,ifid_f,idex_f,exm_f,req} for current inputs.
  function automatic logic [7:0] model_out();
    bit acc   = exm_memread | exm_memwrite;
    bit tk    = exm_branch & exm_zero;
    bit stall = acc & !dmem_ready;
    bit hz    = idex_memread && (idex_rd != 0) &&
                ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    logic [7:0] o = 8'h00;
    if (m_wait) begin
      o[0] = 1'b1;
      if (dmem_ready) begin
        o[7:4] = 4'hF;
        if (tk) o[3:1] = 3'b111;
      end
    end else if (m_flush_left > 0) begin
      if (!stall) begin
        o[7:4] = 4'hF;
        o[3:2] = 2'b11;
      end
    end else begin
      o[0] = acc;
      if (stall) o[7:1] = 7'h00;
      else if (tk) o[7:1] = 7'h7F;
      else if (hz) begin
        o[5:4] = 2'b11;
        o[2]   = 1'b1;
      end else o[7:4] = 4'hF;
    end
    return o;
  endfunction

  // Advance the model across one rising edge.
  function automatic void model_step();
    bit acc   = exm_memread | exm_memwrite;
    bit tk    = exm_branch & exm_zero;
    bit stall = acc & !dmem_ready;
    if (m_wait) begin
      if (!dmem_ready) begin
        if (m_waited < TO) m_waited++;
      end else begin
        m_wait   = 1'b0;
        m_waited = 0;
        if (tk) m_flush_left = FC - 1;
      end
    end else if (m_flush_left > 0) begin
      if (stall) begin
        m_wait   = 1'b1;
        m_waited = 1;
      end else m_flush_left--;
    end else begin
      if (stall) begin
        m_wait   = 1'b1;
        m_waited = 1;
      end else if (tk) m_flush_left = FC - 1;
    end
    if (m_waited >= TO) m_err = 1'b1;
  endfunction

  function automatic void model_reset();
    m_wait       = 1'b0;
    m_flush_left = 0;
    m_waited     = 0;
    m_err        = 1'b0;
  endfunction

  task automatic clear_inputs();
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; idex_rd = 5'd0; idex_memread = 1'b0;
    exm_branch = 1'b0; exm_zero = 1'b0; exm_memread = 1'b0; exm_memwrite = 1'b0;
    dmem_ready = 1'b1;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    #1;
    chk({tag, "_out"}, 32'(out_vec), 32'(model_out()));
    chk({tag, "_state"}, 32'(state), 32'(model_state()));
    chk({tag, "_err"}, 32'(mem_err), 32'(m_err));
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Assert reset part-way through the low phase and check the async response.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    chk({tag, "_out"}, 32'(out_vec), 32'h0E);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_err"}, 32'(mem_err), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_out", 32'(out_vec), 32'h0E);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    cycle("idle");

    // Load-use on rs2, then clean cycle
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; ifid_rs1 = 5'd1;
    cycle("lu");
    clear_inputs();
    cycle("lu_after");

    // rd == 0 must not stall
    idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0;
    cycle("rd0");
    clear_inputs();

    // Taken branch followed by FLUSH cycles
    exm_branch = 1'b1; exm_zero = 1'b1;
    cycle("br");
    clear_inputs();
    idex_memread = 1'b1; idex_rd = 5'd3; ifid_rs1 = 5'd3;
    for (int i = 0; i < 3; i++) cycle("br_flush");
    clear_inputs();
    cycle("br_done");

    // Not-taken branch
    exm_branch = 1'b1; exm_zero = 1'b0;
    cycle("br_nt");
    clear_inputs();

    // Multi-cycle memory access
    exm_memread = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle("mw");
    dmem_ready = 1'b1;
    cycle("mw_rel");
    clear_inputs();
    cycle("mw_after");

    // Timeout: hold ready low past MEM_TIMEOUT
    exm_memwrite = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < TO + 2; i++) cycle("to");
    chk("to_err_set", 32'(mem_err), 32'd1);
    dmem_ready = 1'b1; exm_branch = 1'b1; exm_zero = 1'b1;
    cycle("to_rel_br");
    clear_inputs();
    for (int i = 0; i < 3; i++) cycle("to_after");
    chk("to_err_sticky", 32'(mem_err), 32'd1);

    // Async reset in the middle of a memory wait
    exm_memread = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("rst_mw_pre");
    pulse_reset("rst_mw");
    clear_inputs();
    cycle("rst_mw_post");

    // Async reset in the middle of FLUSH
    exm_branch = 1'b1; exm_zero = 1'b1;
    cycle("rst_fl_pre");
    clear_inputs();
    pulse_reset("rst_fl");
    cycle("rst_fl_post");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ifid_rs1     = 5'($urandom_range(0, 3));
      ifid_rs2     = 5'($urandom_range(0, 3));
      idex_rd      = 5'($urandom_range(0, 3));
      idex_memread = ($urandom_range(0, 2) == 0);
      exm_branch   = ($urandom_range(0, 3) == 0);
      exm_zero     = ($urandom_range(0, 1) == 0);
      case ($urandom_range(0, 7))
        0: begin exm_memread = 1'b1; exm_memwrite = 1'b0; end
        1: begin exm_memread = 1'b0; exm_memwrite = 1'b1; end
        2: begin exm_memread = 1'b1; exm_memwrite = 1'b1; end
        default: begin exm_memread = 1'b0; exm_memwrite = 1'b0; end
      endcase
      dmem_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) pulse_reset("rnd_rst");
      else cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
